// File: rtl/pcileech_cfg_pkg.sv
// ----------------------------------------------------------------------------
// pcileech_cfg_pkg
// Shared definitions for the configuration-space requester:
//   - cfg_req_state_t : requester FSM states
//   - CPL_SC/UR/CA    : completion status encodings
//   - be_first_offset : byte offset of the lowest enabled byte in a first-DW BE
// ----------------------------------------------------------------------------
package pcileech_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_WAIT_WR,
        ST_CPL
    } cfg_req_state_t;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;
    localparam logic [2:0] CPL_CA = 3'b100;

    // Index of the lowest set byte enable; an all-zero BE maps to offset 0.
    function automatic logic [1:0] be_first_offset(input logic [3:0] be);
        logic [1:0] off;
        off = 2'd0;
        if (be[0])      off = 2'd0;
        else if (be[1]) off = 2'd1;
        else if (be[2]) off = 2'd2;
        else if (be[3]) off = 2'd3;
        return off;
    endfunction

endpackage

// File: rtl/pcileech_tlps128_cfgspace_requester.sv
// ----------------------------------------------------------------------------
// pcileech_tlps128_cfgspace_requester
// Initiator side of the extended configuration access interface. Takes decoded
// CfgRd/CfgWr requests, issues one read or write strobe to the configuration
// shadow, waits for its answer and returns one completion descriptor.
//
// Optional feature macro: CFG_REQ_TIMEOUT_EN
//   defined   : reads abandoned after TIMEOUT_CYCLES WAIT_RD cycles (status CA),
//               timeout_count counts them (saturating).
//   undefined : reads wait indefinitely, timeout_count tied to 0.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_*                        request handshake and fields
//   cfg_ext_*                    strobes / latched fields to the shadow,
//                                read data + valid back from it
//   cpl_*                        completion descriptor handshake and fields
//   timeout_count                saturating count of timed-out reads
// ----------------------------------------------------------------------------
module pcileech_tlps128_cfgspace_requester
    import pcileech_cfg_pkg::*;
#(
    parameter int unsigned NUM_FUNCTIONS  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_write,
    input  logic [9:0]  req_reg_num,
    input  logic [3:0]  req_func,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_data,
    input  logic [7:0]  req_tag,
    input  logic [15:0] req_requester_id,

    output logic        cfg_ext_read_received,
    output logic        cfg_ext_write_received,
    output logic [9:0]  cfg_ext_register_number,
    output logic [3:0]  cfg_ext_function_number,
    output logic [31:0] cfg_ext_write_data,
    output logic [3:0]  cfg_ext_write_byte_enable,
    input  logic [31:0] cfg_ext_read_data,
    input  logic        cfg_ext_read_data_valid,

    output logic        cpl_valid,
    input  logic        cpl_ready,
    output logic [2:0]  cpl_status,
    output logic        cpl_has_data,
    output logic [31:0] cpl_data,
    output logic [7:0]  cpl_tag,
    output logic [15:0] cpl_requester_id,
    output logic [6:0]  cpl_lower_addr,
    output logic [15:0] timeout_count
);

    if (TIMEOUT_CYCLES < 3 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must lie in 3..65535");
    end

    cfg_req_state_t state, state_next;

    logic is_write_q;
    logic wr_wait_q;      // second WAIT_WR cycle marker
    logic accept;
    logic unsupported;
    logic timeout_hit;
    logic rd_strobe;
    logic wr_strobe;

    assign unsupported = 32'(req_func) >= NUM_FUNCTIONS;

    // ------------------------------------------------------------------------
    // Optional read timeout
    // ------------------------------------------------------------------------
`ifdef CFG_REQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;
    logic [15:0] to_total;

    // to_cnt holds the number of WAIT_RD cycles already spent without valid;
    // the cycle in which it would reach TIMEOUT_CYCLES takes the CA exit.
    assign timeout_hit   = (state == ST_WAIT_RD) && (to_cnt == TO_LAST);
    assign timeout_count = to_total;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt   <= '0;
            to_total <= '0;
        end else begin
            if (state == ST_ISSUE) begin
                to_cnt <= '0;
            end else if (state == ST_WAIT_RD && !cfg_ext_read_data_valid) begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (timeout_hit && !cfg_ext_read_data_valid && to_total != '1) begin
                to_total <= to_total + 16'd1;
            end
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign timeout_count = '0;
`endif

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        rd_strobe  = 1'b0;
        wr_strobe  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = unsupported ? ST_CPL : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rd_strobe  = !is_write_q;
                wr_strobe  = is_write_q;
                state_next = is_write_q ? ST_WAIT_WR : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (cfg_ext_read_data_valid || timeout_hit) state_next = ST_CPL;
            end
            ST_WAIT_WR: begin
                if (wr_wait_q) state_next = ST_CPL;
            end
            ST_CPL: begin
                if (cpl_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // reset_n is folded in so that req_ready reads 0 while reset is held.
    assign req_ready              = (state == ST_IDLE) && reset_n;
    assign cpl_valid              = (state == ST_CPL);
    assign cfg_ext_read_received  = rd_strobe;
    assign cfg_ext_write_received = wr_strobe;

    // ------------------------------------------------------------------------
    // Datapath latch and completion descriptor
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_write_q                <= 1'b0;
            wr_wait_q                 <= 1'b0;
            cfg_ext_register_number   <= '0;
            cfg_ext_function_number   <= '0;
            cfg_ext_write_data        <= '0;
            cfg_ext_write_byte_enable <= '0;
            cpl_status                <= CPL_SC;
            cpl_has_data              <= 1'b0;
            cpl_data                  <= '0;
            cpl_tag                   <= '0;
            cpl_requester_id          <= '0;
            cpl_lower_addr            <= '0;
        end else begin
            wr_wait_q <= (state == ST_WAIT_WR) && !wr_wait_q;

            if (accept) begin
                is_write_q                <= req_is_write;
                cfg_ext_register_number   <= req_reg_num;
                cfg_ext_function_number   <= req_func;
                cfg_ext_write_data        <= req_data;
                cfg_ext_write_byte_enable <= req_be;
                cpl_status                <= unsupported ? CPL_UR : CPL_SC;
                cpl_has_data              <= !req_is_write;
                cpl_data                  <= '0;
                cpl_tag                   <= req_tag;
                cpl_requester_id          <= req_requester_id;
                cpl_lower_addr            <= {req_reg_num[4:0], be_first_offset(req_be)};
            end

            if (state == ST_WAIT_RD) begin
                if (cfg_ext_read_data_valid) begin
                    cpl_status <= CPL_SC;
                    cpl_data   <= cfg_ext_read_data;
                end else if (timeout_hit) begin
                    cpl_status <= CPL_CA;
                    cpl_data   <= '0;
                end
            end

            if (state == ST_WAIT_WR && wr_wait_q) begin
                cpl_status   <= CPL_SC;
                cpl_has_data <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcileech_tlps128_cfgspace_requester.sv
// ----------------------------------------------------------------------------
// Bench for pcileech_tlps128_cfgspace_requester (NUM_FUNCTIONS=1,
// TIMEOUT_CYCLES=8). Expected completions are queued when a request is driven
// and compared when cpl_valid appears. Bench also acts as the config shadow.
// ----------------------------------------------------------------------------
module tb_pcileech_tlps128_cfgspace_requester;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_write;
    logic [9:0]  req_reg_num;
    logic [3:0]  req_func;
    logic [3:0]  req_be;
    logic [31:0] req_data;
    logic [7:0]  req_tag;
    logic [15:0] req_requester_id;
    logic        cfg_ext_read_received;
    logic        cfg_ext_write_received;
    logic [9:0]  cfg_ext_register_number;
    logic [3:0]  cfg_ext_function_number;
    logic [31:0] cfg_ext_write_data;
    logic [3:0]  cfg_ext_write_byte_enable;
    logic [31:0] cfg_ext_read_data;
    logic        cfg_ext_read_data_valid;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [2:0]  cpl_status;
    logic        cpl_has_data;
    logic [31:0] cpl_data;
    logic [7:0]  cpl_tag;
    logic [15:0] cpl_requester_id;
    logic [6:0]  cpl_lower_addr;
    logic [15:0] timeout_count;

    pcileech_tlps128_cfgspace_requester #(
        .NUM_FUNCTIONS (1),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .req_valid                 (req_valid),
        .req_ready                 (req_ready),
        .req_is_write              (req_is_write),
        .req_reg_num               (req_reg_num),
        .req_func                  (req_func),
        .req_be                    (req_be),
        .req_data                  (req_data),
        .req_tag                   (req_tag),
        .req_requester_id          (req_requester_id),
        .cfg_ext_read_received     (cfg_ext_read_received),
        .cfg_ext_write_received    (cfg_ext_write_received),
        .cfg_ext_register_number   (cfg_ext_register_number),
        .cfg_ext_function_number   (cfg_ext_function_number),
        .cfg_ext_write_data        (cfg_ext_write_data),
        .cfg_ext_write_byte_enable (cfg_ext_write_byte_enable),
        .cfg_ext_read_data         (cfg_ext_read_data),
        .cfg_ext_read_data_valid   (cfg_ext_read_data_valid),
        .cpl_valid                 (cpl_valid),
        .cpl_ready                 (cpl_ready),
        .cpl_status                (cpl_status),
        .cpl_has_data              (cpl_has_data),
        .cpl_data                  (cpl_data),
        .cpl_tag                   (cpl_tag),
        .cpl_requester_id          (cpl_requester_id),
        .cpl_lower_addr            (cpl_lower_addr),
        .timeout_count             (timeout_count)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] ST_SC = 3'b000;
    localparam logic [2:0] ST_UR = 3'b001;
    localparam logic [2:0] ST_CA = 3'b100;

    typedef struct {
        logic        wr;
        logic [9:0]  reg_num;
        logic [3:0]  func;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [31:0] shadow;
        int          sc;      // cycle the shadow answers (0 = never)
        int          hold;    // cycles cpl_ready held low once cpl_valid seen
        logic [2:0]  status;
        logic        chk_hd;
        logic        hd;
        logic [31:0] data;
        logic [6:0]  lower;
        int          lat;     // cycle cpl_valid first seen (accept edge = 0)
    } vec_t;

    typedef struct {
        logic [2:0]  status;
        logic        chk_hd;
        logic        hd;
        logic [31:0] data;
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [6:0]  lower;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vt[11];

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    always @(negedge clk) begin
        if (cfg_ext_read_received)  rd_cnt++;
        if (cfg_ext_write_received) wr_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [9:0] rn, input logic [3:0] fn,
                                input logic [3:0] be, input logic [31:0] wd, input logic [7:0] tag,
                                input logic [15:0] rid, input logic [31:0] sh, input int sc,
                                input int hold, input logic [2:0] st, input logic chk_hd,
                                input logic hd, input logic [31:0] d, input logic [6:0] la,
                                input int lat);
        vec_t v;
        v.wr = wr; v.reg_num = rn; v.func = fn; v.be = be; v.wdata = wd; v.tag = tag;
        v.rid = rid; v.shadow = sh; v.sc = sc; v.hold = hold; v.status = st;
        v.chk_hd = chk_hd; v.hd = hd; v.data = d; v.lower = la; v.lat = lat;
        return v;
    endfunction

    task automatic check_reset_zero(input string pfx);
        chk({pfx, "_ctrl"}, 32'({req_ready, cfg_ext_read_received, cfg_ext_write_received,
                               cpl_valid, cpl_status, cpl_has_data, cpl_lower_addr}), 0);
        chk({pfx, "_cfg_fields"}, 32'({cfg_ext_register_number, cfg_ext_function_number,
                                     cfg_ext_write_byte_enable}), 0);
        chk({pfx, "_cfg_wdata"}, cfg_ext_write_data, 0);
        chk({pfx, "_cpl_data"}, cpl_data, 0);
        chk({pfx, "_tag_rid"}, 32'({cpl_tag, cpl_requester_id}), 0);
        chk({pfx, "_timeout_count"}, 32'(timeout_count), 0);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t g;
        int   cyc;
        int   rd0;
        int   wr0;
        bit   seen;
        bit   legal;
        bit   hold_ok;
        bit   bp_ok;
        legal = (v.status != ST_UR);
        chk("req_ready_idle", 32'(req_ready), 1);
        cpl_ready        = (v.hold == 0);
        req_is_write     = v.wr;
        req_reg_num      = v.reg_num;
        req_func         = v.func;
        req_be           = v.be;
        req_data         = v.wdata;
        req_tag          = v.tag;
        req_requester_id = v.rid;
        req_valid        = 1'b1;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid        = 1'b0;
        req_is_write     = 1'($urandom);
        req_reg_num      = 10'($urandom);
        req_func         = 4'($urandom);
        req_be           = 4'($urandom);
        req_data         = $urandom;
        req_tag          = 8'($urandom);
        req_requester_id = 16'($urandom);
        e.status = v.status; e.chk_hd = v.chk_hd; e.hd = v.hd; e.data = v.data;
        e.tag = v.tag; e.rid = v.rid; e.lower = v.lower; e.lat = v.lat;
        sb.push_back(e);

        cyc = 1; seen = 0; hold_ok = 1;
        while (!seen && cyc <= 80) begin
            if (cyc == 1)
                chk("strobe_cycle1", 32'({cfg_ext_read_received, cfg_ext_write_received}),
                    legal ? (v.wr ? 32'h1 : 32'h2) : 32'h0);
            if (cfg_ext_register_number !== v.reg_num || cfg_ext_function_number !== v.func ||
                cfg_ext_write_data !== v.wdata || cfg_ext_write_byte_enable !== v.be)
                hold_ok = 0;
            cfg_ext_read_data_valid = (v.sc != 0 && cyc == v.sc);
            cfg_ext_read_data       = cfg_ext_read_data_valid ? v.shadow : $urandom;
            if (cpl_valid) seen = 1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        cfg_ext_read_data_valid = 1'b0;
        chk("cpl_seen", 32'(seen), 1);
        g = sb.pop_front();
        chk("latency", cyc, g.lat);

        if (v.hold > 0) begin
            bp_ok = 1;
            for (int h = 0; h < v.hold; h++) begin
                req_valid = 1'b1;
                req_func  = 4'd0;
                @(posedge clk); #1;
                if (!cpl_valid || req_ready || cpl_status !== g.status || cpl_data !== g.data ||
                    cpl_tag !== g.tag || cpl_requester_id !== g.rid || cpl_lower_addr !== g.lower ||
                    cfg_ext_register_number !== v.reg_num || cfg_ext_write_data !== v.wdata)
                    bp_ok = 0;
            end
            req_valid = 1'b0;
            chk("backpressure_hold", 32'(bp_ok), 1);
            cpl_ready = 1'b1;
        end

        chk("cpl_status", 32'(cpl_status), 32'(g.status));
        if (g.chk_hd) chk("cpl_has_data", 32'(cpl_has_data), 32'(g.hd));
        chk("cpl_data", cpl_data, g.data);
        chk("cpl_tag", 32'(cpl_tag), 32'(g.tag));
        chk("cpl_requester_id", 32'(cpl_requester_id), 32'(g.rid));
        chk("cpl_lower_addr", 32'(cpl_lower_addr), 32'(g.lower));
        chk("cfg_fields_hold", 32'(hold_ok), 1);
        @(posedge clk); #1;
        chk("cpl_released", 32'(cpl_valid), 0);
        chk("rd_strobe_count", rd_cnt - rd0, (legal && !v.wr) ? 1 : 0);
        chk("wr_strobe_count", wr_cnt - wr0, (legal && v.wr) ? 1 : 0);
    endtask

    initial begin
        bit late_ok;
        int rd0;

        reset_n = 1'b0;
        req_valid = 1'b0; req_is_write = 1'b0; req_reg_num = '0; req_func = '0;
        req_be = '0; req_data = '0; req_tag = '0; req_requester_id = '0;
        cfg_ext_read_data = '0; cfg_ext_read_data_valid = 1'b0; cpl_ready = 1'b1;

        vt[0]  = mk(0, 10'h001, 4'd0,  4'b1111, 32'h0,        8'h12, 16'h0100, 32'h00100007, 3, 0,
                    ST_SC, 1, 1, 32'h00100007, 7'h04, 4);
        vt[1]  = mk(1, 10'h001, 4'd0,  4'b0011, 32'h00000006, 8'h13, 16'h0100, 32'h0,        0, 0,
                    ST_SC, 1, 0, 32'h0,        7'h04, 4);
        vt[2]  = mk(0, 10'h010, 4'd2,  4'b0100, 32'h11111111, 8'h14, 16'h0200, 32'h0,        0, 0,
                    ST_UR, 0, 0, 32'h0,        7'h42, 1);
        vt[3]  = mk(1, 10'h3FF, 4'd0,  4'b0000, 32'hFFFFFFFF, 8'h15, 16'hFFFF, 32'h0,        0, 0,
                    ST_SC, 1, 0, 32'h0,        7'h7C, 4);
        vt[4]  = mk(0, 10'h2A5, 4'd0,  4'b1000, 32'h0,        8'hFE, 16'hBEEF, 32'hDEADBEEF, 3, 0,
                    ST_SC, 1, 1, 32'hDEADBEEF, 7'h17, 4);
        vt[5]  = mk(1, 10'h005, 4'd15, 4'b1111, 32'h55555555, 8'h16, 16'h0300, 32'h0,        0, 0,
                    ST_UR, 1, 0, 32'h0,        7'h14, 1);
        vt[6]  = mk(0, 10'h01F, 4'd0,  4'b0110, 32'h0,        8'h17, 16'h0400, 32'h12345678, 2, 0,
                    ST_SC, 1, 1, 32'h12345678, 7'h7D, 3);
        vt[7]  = mk(0, 10'h020, 4'd0,  4'b0010, 32'h0,        8'h18, 16'h0500, 32'hCAFEF00D, 9, 0,
                    ST_SC, 1, 1, 32'hCAFEF00D, 7'h01, 10);
`ifdef CFG_REQ_TIMEOUT_EN
        vt[8]  = mk(0, 10'h004, 4'd0,  4'b1111, 32'h0,        8'h20, 16'h0600, 32'h0,        0, 0,
                    ST_CA, 0, 0, 32'h0,        7'h10, 10);
`else
        vt[8]  = mk(0, 10'h004, 4'd0,  4'b1111, 32'h0,        8'h20, 16'h0600, 32'hA5A5A5A5, 60, 0,
                    ST_SC, 1, 1, 32'hA5A5A5A5, 7'h10, 61);
`endif
        vt[9]  = mk(0, 10'h002, 4'd0,  4'b1111, 32'h0,        8'h21, 16'h0700, 32'h0BADF00D, 3, 10,
                    ST_SC, 1, 1, 32'h0BADF00D, 7'h08, 4);
        vt[10] = mk(1, 10'h155, 4'd0,  4'b1100, 32'h12345678, 8'h22, 16'h0800, 32'h0,        0, 10,
                    ST_SC, 1, 0, 32'h0,        7'h56, 4);

        #2;
        check_reset_zero("reset_init");
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i <= 8; i++) run_vec(vt[i]);

`ifdef CFG_REQ_TIMEOUT_EN
        chk("timeout_count_after_ca", 32'(timeout_count), 1);
`else
        chk("timeout_count_tied", 32'(timeout_count), 0);
`endif

        // Late / stray read valid while idle must be ignored.
        late_ok = 1;
        rd0 = rd_cnt;
        for (int i = 0; i < 3; i++) begin
            cfg_ext_read_data_valid = 1'b1;
            cfg_ext_read_data       = 32'hFFFFFFFF;
            @(posedge clk); #1;
            if (cpl_valid || !req_ready) late_ok = 0;
        end
        cfg_ext_read_data_valid = 1'b0;
        chk("late_valid_ignored", 32'(late_ok), 1);
        chk("late_valid_no_strobe", rd_cnt - rd0, 0);

        run_vec(vt[0]);
        for (int i = 9; i <= 10; i++) run_vec(vt[i]);

`ifdef CFG_REQ_TIMEOUT_EN
        chk("timeout_count_stable", 32'(timeout_count), 1);
`else
        chk("timeout_count_stable", 32'(timeout_count), 0);
`endif

        // Reset while waiting for read data.
        req_is_write = 1'b0; req_reg_num = 10'h003; req_func = 4'd0; req_be = 4'b1111;
        req_data = 32'h89ABCDEF; req_tag = 8'h33; req_requester_id = 16'h0900;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_reset_zero("reset_mid");
        #7;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(req_ready), 1);
        chk("no_cpl_after_reset", 32'(cpl_valid), 0);
        run_vec(vt[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcileech_tlps128_cfgspace_requester.md
# pcileech_tlps128_cfgspace_requester

Initiator side of the extended configuration access interface. Accepts decoded configuration requests (CfgRd/CfgWr fields from the 128-bit TLP path), drives the `cfg_ext_*` handshake into the configuration space shadow and waits for its answer. Returns one completion descriptor per request to the completion TLP builder. Protocol timing checks and unsupported-function rejection happen here, so the shadow only ever sees legal, well-spaced accesses.

## Interface
Parameters:
- NUM_FUNCTIONS, 1: implemented functions; `req_func >= NUM_FUNCTIONS` completes UR without touching the shadow.
- TIMEOUT_CYCLES, 64: WAIT_RD cycles before the read is abandoned (requires `CFG_REQ_TIMEOUT_EN`); legal range 3..65535.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when both are high.
- req_is_write  in  1  1 = CfgWr, 0 = CfgRd.
- req_reg_num  in  10  dword register number (byte address [11:2]).
- req_func  in  4  function number.
- req_be  in  4  first-DW byte enables.
- req_data  in  32  write data.
- req_tag  in  8  TLP tag.
- req_requester_id  in  16  requester ID.
- cfg_ext_read_received  out  1  one-cycle read strobe.
- cfg_ext_write_received  out  1  one-cycle write strobe.
- cfg_ext_register_number  out  10  latched register number.
- cfg_ext_function_number  out  4  latched function.
- cfg_ext_write_data  out  32  latched write data.
- cfg_ext_write_byte_enable  out  4  latched byte enables.
- cfg_ext_read_data  in  32  shadow read data.
- cfg_ext_read_data_valid  in  1  shadow read data qualifier.
- cpl_valid  out  1  completion descriptor valid.
- cpl_ready  in  1  completion consumed.
- cpl_status  out  3  000 SC, 001 UR, 100 CA.
- cpl_has_data  out  1  1 for read completions.
- cpl_data  out  32  read data. It is 0 on UR, on CA and on writes.
- cpl_tag  out  8  echoed tag.
- cpl_requester_id  out  16  echoed requester ID.
- cpl_lower_addr  out  7  `{reg_num[4:0], first-enabled-byte offset}`.
- timeout_count  out  16  saturating count of timed-out reads.

## Operation
- Registered FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR, CPL.
- IDLE:
  - `req_ready` = 1 (combinational from state).
  - On handshake, latch all request fields.
  - If `req_func >= NUM_FUNCTIONS`, load status UR and go to CPL.
  - Otherwise go to ISSUE.
- ISSUE: assert exactly one strobe (read or write) for one cycle, then go to WAIT_RD or WAIT_WR.
- WAIT_RD:
  - On `cfg_ext_read_data_valid`, capture the data with status SC and go to CPL.
  - On timeout, load status CA with data 0, increment `timeout_count` (saturating at FFFF) and go to CPL.
- WAIT_WR: stay exactly 2 cycles (covers the shadow's WRITE and COMPLETE states), load SC with `has_data` = 0, then go to CPL.
- CPL: `cpl_valid` = 1 and all `cpl_*` fields held stable until `cpl_ready`; then go to IDLE.
- `cfg_ext_register_number`, `cfg_ext_function_number`, `cfg_ext_write_data` and `cfg_ext_write_byte_enable`:
  - Hold stable from ISSUE through CPL.
  - Change only on request acceptance.
- `cfg_ext_read_data_valid` outside WAIT_RD, including a late valid after timeout, is ignored.
- First-enabled-byte offset is the index of the lowest set BE bit; BE = 0000 gives 0.
- Writes with BE = 0000 are still issued to the shadow (no-op there) and complete SC.

## Timing
- Accept edge = cycle 0. Strobe is high in cycle 1.
- The shadow returns valid in cycle 3, so `cpl_valid` rises in cycle 4.
- Writes also reach `cpl_valid` in cycle 4.
- A UR request reaches `cpl_valid` in cycle 1.
- Minimum spacing between strobes is 5 cycles (with `cpl_ready` tied high); the shadow requires at least 3.
- Timeout:
  - The counter clears on entering WAIT_RD and increments each WAIT_RD cycle without valid.
  - CA is taken when the count equals TIMEOUT_CYCLES.
  - Valid and timeout in the same cycle: valid wins.
- Reset values (asynchronous, at any point mid-transaction):
  - State returns to IDLE.
  - Every output is 0 except `req_ready`, which is 1 after release.
  - `timeout_count` clears.
  - A pending completion is discarded.

## Configuration
- `CFG_REQ_TIMEOUT_EN` defined: timeout counter and `timeout_count` are implemented as above.
- `CFG_REQ_TIMEOUT_EN` undefined:
  - WAIT_RD waits indefinitely for valid.
  - `timeout_count` is tied to 0.
  - TIMEOUT_CYCLES is ignored.
  - No counter logic is synthesized.

## Structure
- Shared package `pcileech_cfg_pkg` holds:
  - the FSM state enum;
  - the status constants CPL_SC = 3'b000, CPL_UR = 3'b001, CPL_CA = 3'b100;
  - the function `be_first_offset(logic [3:0]) -> logic [1:0]`.
- No sub-module: the block is a single FSM with a datapath latch.

## Test plan
- **Read**: read reg 0x001, func 0, tag 0x12, BE 1111; shadow returns 0x00100007 in cycle 3 → `cpl_valid` in cycle 4 with SC, data 0x00100007, tag 0x12, `lower_addr` 0x04.
- **Write**: write reg 0x001, data 0x00000006, BE 0011 → `write_received` pulse in cycle 1, outputs stable through cycle 4; completion SC with `has_data` 0 in cycle 4.
- **Unsupported function**: func 2 with NUM_FUNCTIONS = 1 → no strobe, UR in cycle 1, `cpl_data` 0.
- **Timeout** (macro on, TIMEOUT_CYCLES = 8): shadow never answers → CA after 8 WAIT_RD cycles and `timeout_count` = 1; a late valid is ignored and the next read completes normally.
- **Backpressure**: `cpl_ready` low for 10 cycles → descriptor held unchanged, `req_ready` stays 0, no new strobe.
- **Reset mid-transaction**: `reset_n` asserted in WAIT_RD → all outputs 0 immediately; after release `req_ready` = 1 and a new read completes in 4 cycles.
